// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and control unit for the five-stage MIPS pipeline. It covers the
//   hazards that operand forwarding cannot resolve:
//     - load-use dependencies on the instruction in EX,
//     - HI/LO consumers and new mult/div while the multiply/divide unit is busy,
//     - wrong-path instructions behind a taken branch.
//   It also tracks the multiply/divide operation in flight and counts stall
//   cycles in a saturating counter.
//
// Ports
//   clk             clock
//   rst_n           synchronous active-low reset
//   ID_Rs, ID_Rt    source registers of the ID instruction
//   ID_useRs/Rt     ID instruction really reads Rs / Rt
//   ID_isMD         ID instruction is mult/multu/div/divu
//   ID_readsHiLo    ID instruction is mfhi/mflo
//   EX_memRead      EX instruction is a load
//   EX_Rd           destination register of the EX instruction
//   EX_branchTaken  branch in EX resolved taken
//   PC_write        PC update enable
//   IFID_write      IF/ID write enable
//   IFID_flush      clear IF/ID to a nop
//   IDEX_flush      load a bubble into ID/EX
//   md_start        one-cycle issue pulse to the multiply/divide unit
//   md_busy         multiply/divide operation in flight
//   md_done         last busy cycle, HI/LO written at the end of it
//   stall_cnt       saturating count of stall cycles since reset
//
// States
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | no multiply/divide operation in flight
//   S_BUSY | operation in flight; mdc counts down to 0, mdc==0 is the done cycle

module hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_useRs,
  input  logic             ID_useRt,
  input  logic             ID_isMD,
  input  logic             ID_readsHiLo,
  input  logic             EX_memRead,
  input  logic [4:0]       EX_Rd,
  input  logic             EX_branchTaken,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  localparam logic [3:0]       MDC_RELOAD = 4'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [3:0]       mdc_q, mdc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use;
  logic md_haz;
  logic mdc_tc;
  logic stall_now;

  // Hazard detection
  assign mdc_tc   = (mdc_q == 4'd0);

  assign load_use = EX_memRead && (EX_Rd != 5'd0) &&
                    ((ID_useRs && (EX_Rd == ID_Rs)) ||
                     (ID_useRt && (EX_Rd == ID_Rt)));

  // Only consumers of HI/LO (or a new MD op) wait; in the done cycle the
  // result lands at the end of the cycle and forwarding-free reads are safe.
  assign md_haz   = (state_q == S_BUSY) && !mdc_tc && (ID_isMD || ID_readsHiLo);

  assign md_busy  = (state_q == S_BUSY);
  assign md_done  = (state_q == S_BUSY) && mdc_tc;

  // Pipeline control, first matching rule wins
  always_comb begin
    PC_write   = 1'b1;
    IFID_write = 1'b1;
    IFID_flush = 1'b0;
    IDEX_flush = 1'b0;
    md_start   = 1'b0;
    stall_now  = 1'b0;

    if (!rst_n) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (EX_branchTaken) begin
      // ID holds a wrong-path instruction: squash it, never stall or issue.
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (load_use || md_haz) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
      IDEX_flush = 1'b1;
      stall_now  = 1'b1;
    end else if (ID_isMD) begin
      md_start   = 1'b1;
    end
  end

  // Multiply/divide tracking; an op in flight is older than any branch in EX,
  // so a flush never cancels it.
  always_comb begin
    state_d = state_q;
    mdc_d   = mdc_q;

    case (state_q)
      S_IDLE: begin
        if (md_start) begin
          state_d = S_BUSY;
          mdc_d   = MDC_RELOAD;
        end
      end
      S_BUSY: begin
        if (!mdc_tc) begin
          mdc_d = mdc_q - 4'd1;
        end else if (md_start) begin
          // back-to-back issue in the done cycle, no idle gap
          mdc_d = MDC_RELOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        mdc_d   = 4'd0;
      end
    endcase
  end

  // Stall counter, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (stall_now && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mdc_q   <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mdc_q   <= mdc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MD_LAT  = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [4:0]       ID_Rs, ID_Rt, EX_Rd;
  logic             ID_useRs, ID_useRt, ID_isMD, ID_readsHiLo;
  logic             EX_memRead, EX_branchTaken;
  logic             PC_write, IFID_write, IFID_flush, IDEX_flush;
  logic             md_start, md_busy, md_done;
  logic [CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: busy cycles remaining for the operation in flight
  // (0 = nothing in flight, 1 = done cycle) and the stall count.
  int   m_left = 0;
  int   m_cnt  = 0;
  logic e_pcw, e_ifw, e_iff, e_idf, e_start, e_busy, e_done, e_stall;

  hazard_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_useRs       (ID_useRs),
    .ID_useRt       (ID_useRt),
    .ID_isMD        (ID_isMD),
    .ID_readsHiLo   (ID_readsHiLo),
    .EX_memRead     (EX_memRead),
    .EX_Rd          (EX_Rd),
    .EX_branchTaken (EX_branchTaken),
    .PC_write       (PC_write),
    .IFID_write     (IFID_write),
    .IFID_flush     (IFID_flush),
    .IDEX_flush     (IDEX_flush),
    .md_start       (md_start),
    .md_busy        (md_busy),
    .md_done        (md_done),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_eval();
    logic lu, mh;
    lu = EX_memRead && (EX_Rd != 0) &&
         ((ID_useRs && EX_Rd == ID_Rs) || (ID_useRt && EX_Rd == ID_Rt));
    mh = (m_left > 1) && (ID_isMD || ID_readsHiLo);
    e_busy  = (m_left > 0);
    e_done  = (m_left == 1);
    e_stall = 1'b0;
    e_start = 1'b0;
    if (!rst_n) begin
      {e_pcw, e_ifw, e_iff, e_idf} = 4'b0011;
    end else if (EX_branchTaken) begin
      {e_pcw, e_ifw, e_iff, e_idf} = 4'b1111;
    end else if (lu || mh) begin
      {e_pcw, e_ifw, e_iff, e_idf} = 4'b0001;
      e_stall = 1'b1;
    end else begin
      {e_pcw, e_ifw, e_iff, e_idf} = 4'b1100;
      e_start = ID_isMD;
    end
  endfunction

  // Advance one clock; inputs are applied and checked mid-cycle.
  task automatic tick();
    logic s, st, r;
    model_eval();
    s  = e_stall;
    st = e_start;
    r  = rst_n;
    @(posedge clk);
    if (!r) begin
      m_left = 0;
      m_cnt  = 0;
    end else begin
      if (st) m_left = MD_LAT;
      else if (m_left > 0) m_left = m_left - 1;
      if (s && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic clear_inputs();
    rst_n          = 1'b1;
    ID_Rs          = 5'd0;
    ID_Rt          = 5'd0;
    ID_useRs       = 1'b0;
    ID_useRt       = 1'b0;
    ID_isMD        = 1'b0;
    ID_readsHiLo   = 1'b0;
    EX_memRead     = 1'b0;
    EX_Rd          = 5'd0;
    EX_branchTaken = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    ID_isMD = 1'b1;
    EX_branchTaken = 1'b1;
    tick();
    tick();
    checks++;
    if ({PC_write, IFID_write, IFID_flush, IDEX_flush, md_start} !== 5'b00110) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00110",
               {PC_write, IFID_write, IFID_flush, IDEX_flush, md_start});
    end
    checks++;
    if (md_busy !== 1'b0 || md_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_md busy=%b done=%b want 0 0", md_busy, md_done);
    end
    checks++;
    if (stall_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d want=0", stall_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    EX_memRead = 1'b1; EX_Rd = 5'd8; ID_Rs = 5'd8; ID_useRs = 1'b1;
    #1;
    checks++;
    if ({PC_write, IFID_write, IFID_flush, IDEX_flush, md_start} !== 5'b00010) begin
      failures++;
      $display("FAIL loaduse_rs got=%b want=00010",
               {PC_write, IFID_write, IFID_flush, IDEX_flush, md_start});
    end
    tick();
    EX_memRead = 1'b0;
    #1;
    checks++;
    if (PC_write !== 1'b1 || stall_cnt !== 4'd1) begin
      failures++;
      $display("FAIL loaduse_after pcw=%b cnt=%0d want 1 1", PC_write, stall_cnt);
    end
    EX_memRead = 1'b1; EX_Rd = 5'd0; ID_Rs = 5'd0;
    #1;
    checks++;
    if (PC_write !== 1'b1 || IDEX_flush !== 1'b0) begin
      failures++;
      $display("FAIL loaduse_r0 pcw=%b idf=%b want 1 0", PC_write, IDEX_flush);
    end
    EX_Rd = 5'd8; ID_Rs = 5'd8; ID_useRs = 1'b0;
    #1;
    checks++;
    if (PC_write !== 1'b1 || IDEX_flush !== 1'b0) begin
      failures++;
      $display("FAIL loaduse_unused pcw=%b idf=%b want 1 0", PC_write, IDEX_flush);
    end
    ID_Rt = 5'd8; ID_useRt = 1'b1;
    #1;
    checks++;
    if (PC_write !== 1'b0 || IFID_write !== 1'b0 || IDEX_flush !== 1'b1) begin
      failures++;
      $display("FAIL loaduse_rt pcw=%b ifw=%b idf=%b want 0 0 1",
               PC_write, IFID_write, IDEX_flush);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (stall_cnt !== 4'd2) begin
      failures++;
      $display("FAIL loaduse_cnt got=%0d want=2", stall_cnt);
    end
  endtask

  task automatic test_md_mfhi();
    do_reset();
    ID_isMD = 1'b1;
    #1;
    checks++;
    if (md_start !== 1'b1 || md_busy !== 1'b0) begin
      failures++;
      $display("FAIL md_issue start=%b busy=%b want 1 0", md_start, md_busy);
    end
    tick();
    ID_isMD = 1'b0; ID_readsHiLo = 1'b1;
    for (int k = 1; k < MD_LAT; k++) begin
      #1;
      checks++;
      if ({md_busy, md_done, PC_write, IDEX_flush} !== 4'b1001) begin
        failures++;
        $display("FAIL md_wait k=%0d got=%b want=1001", k,
                 {md_busy, md_done, PC_write, IDEX_flush});
      end
      tick();
    end
    checks++;
    if ({md_busy, md_done, PC_write, IDEX_flush} !== 4'b1110) begin
      failures++;
      $display("FAIL md_done got=%b want=1110", {md_busy, md_done, PC_write, IDEX_flush});
    end
    tick();
    ID_readsHiLo = 1'b0;
    #1;
    checks++;
    if (md_busy !== 1'b0 || stall_cnt !== 4'(MD_LAT - 1)) begin
      failures++;
      $display("FAIL md_end busy=%b cnt=%0d want 0 %0d", md_busy, stall_cnt, MD_LAT - 1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ID_isMD = 1'b1;
    tick();
    for (int k = 1; k < MD_LAT; k++) begin
      checks++;
      if (md_start !== 1'b0 || PC_write !== 1'b0 || md_busy !== 1'b1) begin
        failures++;
        $display("FAIL b2b_hold k=%0d start=%b pcw=%b busy=%b want 0 0 1",
                 k, md_start, PC_write, md_busy);
      end
      tick();
    end
    checks++;
    if (md_done !== 1'b1 || md_start !== 1'b1) begin
      failures++;
      $display("FAIL b2b_reissue done=%b start=%b want 1 1", md_done, md_start);
    end
    tick();
    ID_isMD = 1'b0;
    #1;
    checks++;
    if (md_busy !== 1'b1 || md_done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_nogap busy=%b done=%b want 1 0", md_busy, md_done);
    end
    for (int k = 1; k < MD_LAT; k++) tick();
    checks++;
    if (md_done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done2 got=%b want=1", md_done);
    end
    tick();
    checks++;
    if (md_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got=%b want=0", md_busy);
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    ID_isMD = 1'b1;
    tick();
    EX_branchTaken = 1'b1; ID_readsHiLo = 1'b1;
    EX_memRead = 1'b1; EX_Rd = 5'd5; ID_Rs = 5'd5; ID_useRs = 1'b1;
    #1;
    checks++;
    if ({PC_write, IFID_write, IFID_flush, IDEX_flush, md_start} !== 5'b11110) begin
      failures++;
      $display("FAIL branch_ctrl got=%b want=11110",
               {PC_write, IFID_write, IFID_flush, IDEX_flush, md_start});
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (stall_cnt !== 4'd0 || md_busy !== 1'b1 || md_done !== 1'b0) begin
      failures++;
      $display("FAIL branch_after cnt=%0d busy=%b done=%b want 0 1 0",
               stall_cnt, md_busy, md_done);
    end
    for (int k = 2; k < MD_LAT; k++) tick();
    checks++;
    if (md_done !== 1'b1) begin
      failures++;
      $display("FAIL branch_md_cont done=%b want=1", md_done);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    EX_memRead = 1'b1; EX_Rd = 5'd3; ID_Rt = 5'd3; ID_useRt = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    checks++;
    if (stall_cnt !== 4'(CNT_MAX) || int'(stall_cnt) != m_cnt) begin
      failures++;
      $display("FAIL sat_cnt got=%0d want=%0d", stall_cnt, CNT_MAX);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_n          = ($urandom_range(0, 99) >= 2);
      ID_Rs          = 5'($urandom_range(0, 3));
      ID_Rt          = 5'($urandom_range(0, 3));
      EX_Rd          = 5'($urandom_range(0, 3));
      ID_useRs       = 1'($urandom_range(0, 1));
      ID_useRt       = 1'($urandom_range(0, 1));
      EX_memRead     = ($urandom_range(0, 99) < 30);
      ID_isMD        = ($urandom_range(0, 99) < 25);
      ID_readsHiLo   = ($urandom_range(0, 99) < 25);
      EX_branchTaken = ($urandom_range(0, 99) < 10);
      #1;
      model_eval();
      checks++;
      if ({PC_write, IFID_write, IFID_flush, IDEX_flush, md_start, md_busy, md_done} !==
          {e_pcw, e_ifw, e_iff, e_idf, e_start, e_busy, e_done}) begin
        failures++;
        $display("FAIL rand_ctrl n=%0d got=%b want=%b", n,
                 {PC_write, IFID_write, IFID_flush, IDEX_flush, md_start, md_busy, md_done},
                 {e_pcw, e_ifw, e_iff, e_idf, e_start, e_busy, e_done});
      end
      checks++;
      if (int'(stall_cnt) != m_cnt) begin
        failures++;
        $display("FAIL rand_cnt n=%0d got=%0d want=%0d", n, stall_cnt, m_cnt);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_md_mfhi();
    test_back_to_back();
    test_branch_priority();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and control unit for the five-stage MIPS core, working alongside the forwarding unit. The forwarding unit supplies data to consumers. This block covers the cases forwarding cannot resolve:
- load-use hazards,
- operands still being produced by the multi-cycle multiply/divide unit,
- wrong-path instructions after a taken branch.

It drives the PC and IF/ID write enables, the IF/ID and ID/EX flush controls, and the multiply/divide issue handshake, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- MD_LATENCY, 4: cycles the multiply/divide unit needs per operation; legal range 2..16.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- ID_Rs, ID_Rt  in  5  source registers of the instruction in ID.
- ID_useRs, ID_useRt  in  1  the ID instruction actually reads Rs / Rt.
- ID_isMD  in  1  the ID instruction is mult/multu/div/divu.
- ID_readsHiLo  in  1  the ID instruction is mfhi/mflo.
- EX_memRead  in  1  the EX instruction is a load.
- EX_Rd  in  5  destination register of the EX instruction.
- EX_branchTaken  in  1  the branch in EX resolved taken.
- PC_write  out  1  PC update enable.
- IFID_write  out  1  IF/ID register write enable.
- IFID_flush  out  1  clear IF/ID to a nop.
- IDEX_flush  out  1  load a bubble into ID/EX.
- md_start  out  1  one-cycle issue pulse to the multiply/divide unit.
- md_busy  out  1  a multiply/divide operation is in flight.
- md_done  out  1  last busy cycle; HI/LO are written at the end of this cycle.
- stall_cnt  out  CNT_W  number of stall cycles since reset, saturating.

## Operation
State:
- FSM with two states: IDLE and BUSY.
- Down-counter mdc, 4 bits.
- stall_cnt register.

Derived conditions:
- loadUse = EX_memRead && EX_Rd != 0 && ((ID_useRs && EX_Rd == ID_Rs) || (ID_useRt && EX_Rd == ID_Rt)).
- mdHaz = state == BUSY && mdc != 0 && (ID_isMD || ID_readsHiLo).
- md_busy = (state == BUSY).
- md_done = (state == BUSY && mdc == 0).

Control outputs, in priority order (first matching rule wins):
1. rst_n == 0: PC_write=0, IFID_write=0, IFID_flush=1, IDEX_flush=1, md_start=0.
2. EX_branchTaken: PC_write=1, IFID_write=1, IFID_flush=1, IDEX_flush=1, md_start=0.
   - The ID instruction is wrong-path, so no stall and no issue.
3. loadUse or mdHaz (stall): PC_write=0, IFID_write=0, IFID_flush=0, IDEX_flush=1, md_start=0.
4. ID_isMD (issue): md_start=1; PC_write=1, IFID_write=1, both flushes 0.
5. Otherwise: PC_write=1, IFID_write=1, both flushes 0, md_start=0.

FSM transitions, taken at posedge:
- IDLE + md_start: go to BUSY, mdc <= MD_LATENCY-1.
- BUSY, mdc != 0: mdc <= mdc-1.
- BUSY, mdc == 0, md_start: stay BUSY, mdc <= MD_LATENCY-1 (back-to-back issue is allowed in the done cycle).
- BUSY, mdc == 0, no md_start: go to IDLE.
- An in-flight operation is older than any branch in EX. It is never cancelled by EX_branchTaken.

stall_cnt:
- Increments by 1 at each posedge where rule 3 applied.
- Saturates at 2^CNT_W-1.
- Flush cycles (rule 2) are not counted.

## Timing
- All control outputs are combinational from the current state and inputs, and valid in the same cycle.
- Reset is sampled at posedge. After the first edge with rst_n=0: state=IDLE, mdc=0, stall_cnt=0, md_busy=0, md_done=0.
- Reset asserted mid-operation abandons the operation: md_busy=0 from the next cycle.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM, and forwarding covers it.
- MD issue in cycle t:
  - md_busy=1 from t+1 through t+MD_LATENCY.
  - md_done=1 in cycle t+MD_LATENCY only.
- A dependent mfhi/mflo/MD instruction held in ID during the operation:
  - stalls in cycles t+1 .. t+MD_LATENCY-1 (MD_LATENCY-1 stall cycles);
  - proceeds in the done cycle.
- Load-use and MD issue in the same cycle: the stall wins, no md_start, and the issue retries the next cycle.
- Branch taken while mdHaz: the flush wins, no stall is counted, and BUSY continues counting.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> PC_write=0, IFID_flush=IDEX_flush=1, md_busy=0, stall_cnt=0.
- Load-use: EX_memRead=1, EX_Rd=8, ID_Rs=8, ID_useRs=1 -> one cycle of PC_write=0, IFID_write=0, IDEX_flush=1, stall_cnt=1. With EX_Rd=0, or ID_useRs=0, -> no stall.
- MD issue then mfhi, MD_LATENCY=4: ID_isMD at t -> md_start=1 at t. mfhi held in ID from t+1 -> stalls t+1..t+3, md_done=1 at t+4 and mfhi proceeds, md_busy=0 at t+5, stall_cnt=3.
- Back-to-back MD: second ID_isMD waits until the done cycle -> md_start=1 in that cycle, md_busy stays 1 with no IDLE gap, next md_done 4 cycles later.
- Branch priority: EX_branchTaken=1 together with loadUse and ID_isMD -> IFID_flush=IDEX_flush=1, PC_write=1, md_start=0, stall_cnt unchanged.
- Saturation, CNT_W=4: 20 consecutive stall cycles -> stall_cnt holds 15.
